// File: rtl/quad_sample_sched.sv
// Sampling scheduler: captures both encoder counts into a coherent snapshot on a timer or count events.
// Optional: define QUAD_SAMPLE_SCHED_MISSCNT_EN to build the saturating missed-sample counter.
module quad_sample_sched #(
    parameter int unsigned COUNT_WIDTH  = 16,
    parameter int unsigned PERIOD_WIDTH = 16,
    parameter int unsigned MISS_WIDTH   = 8
) (
    input  logic                    hba_clk,
    input  logic                    hba_reset_n,
    input  logic [COUNT_WIDTH-1:0]  enc_count0,
    input  logic [COUNT_WIDTH-1:0]  enc_count1,
    input  logic [1:0]              enc_valid,
    input  logic [1:0]              enc_en,
    input  logic                    intr_en,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic                    freeze,
    input  logic                    intr_ack,
    output logic [COUNT_WIDTH-1:0]  snap_count0,
    output logic [COUNT_WIDTH-1:0]  snap_count1,
    output logic                    snap_wr_en,
    output logic [1:0]              changed,
    output logic                    overrun,
    output logic [MISS_WIDTH-1:0]   missed_cnt,
    output logic                    sched_irq
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        CAPTURE,
        COMMIT,
        HOLD
    } state_e;

    state_e                  state_q, state_d;
    logic [PERIOD_WIDTH-1:0] timer_q, timer_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [1:0]              pending_q, pending_d;
    logic [1:0]              chg_acc_q, chg_acc_d;
    logic [COUNT_WIDTH-1:0]  shadow0_q, shadow0_d;
    logic [COUNT_WIDTH-1:0]  shadow1_q, shadow1_d;
    logic [COUNT_WIDTH-1:0]  snap0_q, snap0_d;
    logic [COUNT_WIDTH-1:0]  snap1_q, snap1_d;
    logic [1:0]              changed_q, changed_d;
    logic                    overrun_q, overrun_d;
    logic                    irq_q, irq_d;

    logic [1:0] ev;
    logic       active;
    logic       period_mode;
    logic       wrap;
    logic       trigger;
    logic       capture;
    logic       commit;
    logic       supersede;

    always_comb begin
        ev          = enc_valid & enc_en;
        active      = (enc_en != 2'b00);
        period_mode = (period_q != '0);
        wrap        = period_mode && (timer_q == period_q - PERIOD_WIDTH'(1));
        trigger     = period_mode ? wrap : ((pending_q != 2'b00) || (ev != 2'b00));

        state_d   = state_q;
        capture   = 1'b0;
        commit    = 1'b0;
        supersede = 1'b0;

        case (state_q)
            IDLE: begin
                if (active) state_d = RUN;
            end
            RUN: begin
                if (!active)      state_d = IDLE;
                else if (trigger) state_d = CAPTURE;
            end
            CAPTURE: begin
                capture = 1'b1;
                state_d = COMMIT;
            end
            COMMIT: begin
                if (!freeze) begin
                    commit  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!active) begin
                    state_d = IDLE;
                end else begin
                    if (trigger) begin
                        capture   = 1'b1;
                        supersede = 1'b1;
                    end
                    if (!freeze) state_d = COMMIT;
                end
            end
            default: state_d = IDLE;
        endcase

        // Timer free-runs through CAPTURE/COMMIT/HOLD so the capture cadence equals the period.
        if (state_q == IDLE || !period_mode) timer_d = '0;
        else if (wrap)                       timer_d = '0;
        else                                 timer_d = timer_q + PERIOD_WIDTH'(1);

        // A new period is only adopted at a reload (or while it cannot affect a running count).
        period_d = (state_q == IDLE || !period_mode || wrap) ? period : period_q;

        shadow0_d = shadow0_q;
        shadow1_d = shadow1_q;
        chg_acc_d = chg_acc_q;
        pending_d = pending_q | ev;
        // Events arriving in the capture cycle are folded into that capture, so clearing loses nothing.
        if (capture) begin
            if (enc_en[0]) shadow0_d = enc_count0;
            if (enc_en[1]) shadow1_d = enc_count1;
            chg_acc_d = chg_acc_q | pending_q | ev;
            pending_d = 2'b00;
        end

        snap0_d   = snap0_q;
        snap1_d   = snap1_q;
        changed_d = changed_q;
        if (commit) begin
            snap0_d   = shadow0_q;
            snap1_d   = shadow1_q;
            changed_d = chg_acc_q;
            chg_acc_d = 2'b00;
        end

        if (state_d == IDLE) begin
            timer_d   = '0;
            pending_d = 2'b00;
        end

        irq_d = irq_q;
        if (commit && intr_en) irq_d = 1'b1;
        else if (intr_ack)     irq_d = 1'b0;

        overrun_d = overrun_q;
        if (supersede)     overrun_d = 1'b1;
        else if (intr_ack) overrun_d = 1'b0;
    end

    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            period_q  <= '0;
            pending_q <= 2'b00;
            chg_acc_q <= 2'b00;
            shadow0_q <= '0;
            shadow1_q <= '0;
            snap0_q   <= '0;
            snap1_q   <= '0;
            changed_q <= 2'b00;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            period_q  <= period_d;
            pending_q <= pending_d;
            chg_acc_q <= chg_acc_d;
            shadow0_q <= shadow0_d;
            shadow1_q <= shadow1_d;
            snap0_q   <= snap0_d;
            snap1_q   <= snap1_d;
            changed_q <= changed_d;
            overrun_q <= overrun_d;
            irq_q     <= irq_d;
        end
    end

`ifdef QUAD_SAMPLE_SCHED_MISSCNT_EN
    logic [MISS_WIDTH-1:0] missed_q, missed_d;

    always_comb begin
        missed_d = missed_q;
        if (supersede) begin
            if (missed_q != '1) missed_d = missed_q + MISS_WIDTH'(1);
        end else if (intr_ack) begin
            missed_d = '0;
        end
    end

    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) missed_q <= '0;
        else              missed_q <= missed_d;
    end

    assign missed_cnt = missed_q;
`else
    assign missed_cnt = '0;
`endif

    // Snapshot is presented during the write pulse so the bank latches the new values on that edge.
    assign snap_wr_en  = commit;
    assign snap_count0 = commit ? shadow0_q : snap0_q;
    assign snap_count1 = commit ? shadow1_q : snap1_q;
    assign changed     = commit ? chg_acc_q : changed_q;
    assign overrun     = overrun_q;
    assign sched_irq   = irq_q;

endmodule
